div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the Execute stage next to the ALU. It is the producer side of the divide stall handshake. The hazard unit holds the pipeline (`div_stallE`) while `RtypedivE` is high and `DIV_validE` is low. This block raises `DIV_validE` for exactly one cycle when the result is ready. Special cases (divide-by-zero, signed overflow) finish early. Normal operands take one quotient bit per cycle.

## Interface
- `XLEN`, 32, operand/result width (only 32 is supported)
- `clk` input 1 pipeline clock; all state updates on rising edge
- `reset` input 1 asynchronous, active-high; forces IDLE
- `RtypedivE` input 1 start request: an M-extension divide/remainder instruction is in E
- `funct3E` input 2 funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `srcaE` input XLEN dividend, already forwarded
- `srcbE` input XLEN divisor, already forwarded
- `flushE` input 1 kills any operation in flight
- `busy` output 1 high whenever state != IDLE
- `DIV_validE` output 1 one-cycle result strobe
- `div_resultE` output XLEN quotient or remainder, valid while `DIV_validE` is high

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - If `RtypedivE` is high and `flushE` is low, latch `funct3E`, operands and sign info.
  - Divisor == 0: result = all-ones (DIV/DIVU) or dividend (REM/REMU); go to DONE.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: result = 0x80000000 (DIV) or 0 (REM); go to DONE.
  - Otherwise load |dividend| and |divisor| (signed ops) or raw values (unsigned), clear the partial remainder, set the counter to 31, go to CALC.
- **CALC:** one restoring step per cycle.
  - Shift {rem, quo} left 1.
  - Trial-subtract the divisor from the 33-bit remainder.
  - If the difference is non-negative, keep it and set quo[0].
  - Decrement the counter; after the step with counter == 0, go to DONE.
- **DONE:**
  - Drive `DIV_validE`=1 and `div_resultE`.
  - Sign fix for signed ops only: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Go to IDLE unconditionally.
- **Start handling:** `RtypedivE` is ignored in CALC and DONE, because the same instruction stays held in E while stalled. A new start is accepted only in IDLE, so back-to-back divides are allowed.
- **Flush:** `flushE` high in any state goes to IDLE on the next edge with no strobe. `flushE` together with a start in IDLE: the start is rejected.
- **Reset:** state IDLE; `busy`=0, `DIV_validE`=0, `div_resultE`=0; internal registers cleared.
- `div_resultE` reads 0 outside DONE.
- All arithmetic is in XLEN+1 bits for the trial subtract; no truncation warnings are acceptable.

## Timing
- Start sampled at the end of cycle 0.
- Normal path: CALC occupies cycles 1–32; DONE with `DIV_validE`=1 in cycle 33.
  - 33-cycle latency; the pipeline stalls cycles 0–32.
- Special cases: DONE in cycle 1.
- `DIV_validE` is registered (a state decode), never a combinational function of the inputs.
- `busy` rises in cycle 1 and falls in the cycle after DONE.
- Earliest next start: the cycle after DONE.
- `reset` asserted mid-CALC clears outputs immediately (asynchronously). Operation resumes in IDLE after deassertion; no stale strobe.

## Test plan
- **DIVU:** 100 / 7, start cycle 0 -> `DIV_validE`=1 only in cycle 33, `div_resultE`=14. REMU with the same operands -> 2.
- **Signed:**
  - DIV -7 / 2 -> 0xFFFFFFFD (-3).
  - REM -7 / 2 -> 0xFFFFFFFF (-1).
  - DIV 7 / -2 -> 0xFFFFFFFD.
  - REM 7 / -2 -> 1.
- **Special cases:**
  - DIV 5 / 0 -> 0xFFFFFFFF in cycle 1.
  - REMU 5 / 0 -> 5 in cycle 1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0, both in cycle 1.
- **Flush:** `flushE` pulsed in cycle 10 of CALC -> IDLE in cycle 11, no `DIV_validE`. A new DIVU 9 / 3 started in cycle 11 -> 3 in cycle 44.
- **Hold then back-to-back:** `RtypedivE` held high for cycles 0–33 with changing operands -> result uses the cycle-0 operands only. A second divide accepted in cycle 34 -> valid in cycle 67.
- **Reset mid-CALC:** assert `reset` at cycle 15 -> `busy`=0, `DIV_validE`=0, `div_resultE`=0 immediately; no strobe after release.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RtypedivE,
  input  logic [1:0]      funct3E,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            flushE,
  output logic            busy,
  output logic            DIV_validE,
  output logic [XLEN-1:0] div_resultE
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_rem_q, is_rem_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN:0]     rem_sh, diff;
  logic              fits;
  logic [XLEN-1:0]   rem_nx, quo_nx, quo_fix, rem_fix;

  always_comb begin
    a_neg = ~funct3E[0] & srcaE[XLEN-1];
    b_neg = ~funct3E[0] & srcbE[XLEN-1];
    a_abs = a_neg ? -srcaE : srcaE;
    b_abs = b_neg ? -srcbE : srcbE;

    // The shifted remainder never reaches twice the divisor, so bit XLEN of the
    // difference is a reliable borrow.
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dvsr_q};
    fits    = ~diff[XLEN];
    rem_nx  = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], fits};
    quo_fix = neg_quo_q ? -quo_nx : quo_nx;
    rem_fix = neg_rem_q ? -rem_nx : rem_nx;

    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    res_d     = '0;

    case (state_q)
      IDLE: begin
        if (RtypedivE && !flushE) begin
          is_rem_d = funct3E[1];
          if (srcbE == '0) begin
            res_d   = funct3E[1] ? srcaE : '1;
            state_d = DONE;
          end else if (!funct3E[0] && srcaE == {1'b1, {(XLEN-1){1'b0}}} && srcbE == '1) begin
            res_d   = funct3E[1] ? '0 : srcaE;
            state_d = DONE;
          end else begin
            quo_d     = a_abs;
            dvsr_d    = b_abs;
            rem_d     = '0;
            cnt_d     = CW'(XLEN-1);
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d   = is_rem_q ? rem_fix : quo_fix;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (flushE) begin
      state_d = IDLE;
      res_d   = '0;
    end

    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign DIV_validE  = valid_q;
  assign div_resultE = res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with a reference model
module tb_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        RtypedivE;
  logic [1:0]  funct3E;
  logic [31:0] srcaE, srcbE;
  logic        flushE;
  logic        busy, DIV_validE;
  logic [31:0] div_resultE;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .RtypedivE(RtypedivE), .funct3E(funct3E),
    .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE), .busy(busy),
    .DIV_validE(DIV_validE), .div_resultE(div_resultE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] val;
    int          at;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  function automatic logic special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    sa = a;
    sb = b;
    case (op)
      OP_DIV:  return 32'(sa / sb);
      OP_REM:  return 32'(sa % sb);
      OP_DIVU: return a / b;
      default: return a % b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (DIV_validE) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_strobe: DIV_validE=1 result %h with nothing pending (cycle %0d)", div_resultE, cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("result", div_resultE, mon_e.val);
          check("strobe_cycle", 32'(cyc), 32'(mon_e.at));
        end
      end else begin
        check("result_zero_when_idle", div_resultE, 32'd0);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic expect_it);
    RtypedivE = 1'b1;
    funct3E   = op;
    srcaE     = a;
    srcbE     = b;
    if (expect_it)
      sbq.push_back('{ref_div(op, a, b), cyc + (special(op, a, b) ? 1 : 33)});
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sbq.size() != 0 && k < 80) begin
      @(posedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: %0d results still pending at cycle %0d", sbq.size(), cyc);
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    drive(op, a, b, 1'b1);
    @(posedge clk); #1;
    RtypedivE = 1'b0;
    srcaE = $urandom;
    srcbE = $urandom;
    wait_drain();
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    int          n0;

    reset = 1'b1; RtypedivE = 1'b0; flushE = 1'b0;
    funct3E = 2'b00; srcaE = '0; srcbE = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, DIV_validE}, 32'd0);
    check("reset_result", div_resultE, 32'd0);
    reset = 1'b0;

    run(OP_DIVU, 32'd100, 32'd7);
    run(OP_REMU, 32'd100, 32'd7);
    run(OP_DIV,  32'hFFFF_FFF9, 32'd2);
    run(OP_REM,  32'hFFFF_FFF9, 32'd2);
    run(OP_DIV,  32'd7, 32'hFFFF_FFFE);
    run(OP_REM,  32'd7, 32'hFFFF_FFFE);
    run(OP_DIV,  32'd5, 32'd0);
    run(OP_REMU, 32'd5, 32'd0);
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd1);

    // Flush in CALC cycle 10, then a fresh start in the following cycle.
    @(posedge clk); #1;
    n0 = cyc;
    drive(OP_DIVU, 32'd12345, 32'd11, 1'b0);
    @(posedge clk); #1;
    RtypedivE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_in_calc", {31'd0, busy}, 32'd1);
    flushE = 1'b1;
    @(posedge clk); #1;
    flushE = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_cycle", 32'(cyc), 32'(n0 + 11));
    drive(OP_DIVU, 32'd9, 32'd3, 1'b1);
    @(posedge clk); #1;
    RtypedivE = 1'b0;
    wait_drain();

    // Start held through the stall with changing operands, then back-to-back.
    @(posedge clk); #1;
    drive(OP_DIV, 32'hFFFF_FC18, 32'd7, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      funct3E = 2'($urandom_range(0, 3));
      srcaE   = $urandom;
      srcbE   = $urandom;
    end
    @(posedge clk); #1;
    drive(OP_REMU, 32'd1000, 32'd37, 1'b1);
    @(posedge clk); #1;
    RtypedivE = 1'b0;
    wait_drain();

    // Asynchronous reset in the middle of CALC.
    @(posedge clk); #1;
    drive(OP_DIVU, 32'd99999, 32'd13, 1'b0);
    @(posedge clk); #1;
    RtypedivE = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_valid", {31'd0, DIV_validE}, 32'd0);
    check("midreset_result", div_resultE, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'($urandom_range(0, 100));
        default: ra = $urandom;
      endcase
      run(rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
